// File: rtl/mini_risc_ctrl_pkg.sv
// Shared encodings for the mini-RISC multi-cycle control sequencer:
// FSM states, opcode/func fields, ALU and branch op codes, write-back encodings.
package mini_risc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Opcode classes
    localparam logic [5:0] OP_ALU_R = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_BR    = 6'd5;
    localparam logic [5:0] OP_HALT  = 6'd63;

    // func field for OP_ALU_R
    localparam logic [5:0] F_ADD   = 6'd0;
    localparam logic [5:0] F_COMP  = 6'd1;
    localparam logic [5:0] F_AND   = 6'd2;
    localparam logic [5:0] F_XOR   = 6'd3;
    localparam logic [5:0] F_SHLL  = 6'd4;
    localparam logic [5:0] F_SHRL  = 6'd5;
    localparam logic [5:0] F_SHLLV = 6'd6;
    localparam logic [5:0] F_SHRLV = 6'd7;
    localparam logic [5:0] F_SHRA  = 6'd8;
    localparam logic [5:0] F_SHRAV = 6'd9;

    // func field for OP_BR
    localparam logic [5:0] F_BR   = 6'd0;
    localparam logic [5:0] F_BLTZ = 6'd1;
    localparam logic [5:0] F_BZ   = 6'd2;
    localparam logic [5:0] F_BNZ  = 6'd3;
    localparam logic [5:0] F_BL   = 6'd4;
    localparam logic [5:0] F_BCY  = 6'd5;
    localparam logic [5:0] F_BNCY = 6'd6;

    typedef enum logic [3:0] {
        ALU_NOP   = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_COMP  = 4'd2,
        ALU_AND   = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SHLL  = 4'd5,
        ALU_SHRL  = 4'd6,
        ALU_SHLLV = 4'd7,
        ALU_SHRLV = 4'd8,
        ALU_SHRA  = 4'd9,
        ALU_SHRAV = 4'd10
    } alu_op_t;

    // Branch ops; BR_SEQ means plain PC+4
    localparam logic [4:0] BR_SEQ  = 5'd0;
    localparam logic [4:0] BR_UNC  = 5'd1;
    localparam logic [4:0] BR_BLTZ = 5'd2;
    localparam logic [4:0] BR_BZ   = 5'd3;
    localparam logic [4:0] BR_BNZ  = 5'd4;
    localparam logic [4:0] BR_BL   = 5'd5;
    localparam logic [4:0] BR_BCY  = 5'd6;
    localparam logic [4:0] BR_BNCY = 5'd7;

    // Register-file write select and write-back source
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_RS   = 2'b01;
    localparam logic [1:0] RW_LINK = 2'b10;

    localparam logic [1:0] WBM_LINK = 2'd0;
    localparam logic [1:0] WBM_MEM  = 2'd1;
    localparam logic [1:0] WBM_ALU  = 2'd2;

    // True for every opcode/func pair the sequencer knows how to execute
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ALU_R: ok = (fn <= F_SHRAV);
            OP_ADDI, OP_COMPI, OP_LW, OP_SW, OP_HALT: ok = 1'b1;
            OP_BR:    ok = (fn <= F_BNCY);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// Optional illegal_instr flag present only when ILLEGAL_TRAP_EN is defined.
interface multicycle_controller_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             pc_en;
    logic [1:0]       reg_write;
    logic             imm_mux_ctrl;
    logic             alu_mux_ctrl;
    logic [3:0]       alu_op;
    logic             dmem_enable;
    logic             dmem_write_enable;
    logic [1:0]       reg_write_mux_ctrl;
    logic [4:0]       br_op;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_instr;
`endif

    modport master (
        input  opcode, func,
        output pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
               dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
               halted, instr_count
`ifdef ILLEGAL_TRAP_EN
        , output illegal_instr
`endif
    );

    modport slave (
        output opcode, func,
        input  pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
               dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
               halted, instr_count
`ifdef ILLEGAL_TRAP_EN
        , input illegal_instr
`endif
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational map from (state, latched opcode, latched func) to the
// datapath control bundle. Holds no state of its own.
module ctrl_decode
    import mini_risc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic [5:0] func_q,
    output logic       pc_en,
    output logic [1:0] reg_write,
    output logic       imm_mux_ctrl,
    output logic       alu_mux_ctrl,
    output logic [3:0] alu_op,
    output logic       dmem_enable,
    output logic       dmem_write_enable,
    output logic [1:0] reg_write_mux_ctrl,
    output logic [4:0] br_op,
    output logic       halted
);

    logic legal;
    assign legal = is_legal(op_q, func_q);

    // Decode the control bundle for the current state and instruction class
    always_comb begin
        pc_en              = 1'b0;
        reg_write          = RW_NONE;
        imm_mux_ctrl       = 1'b0;
        alu_mux_ctrl       = 1'b0;
        alu_op             = ALU_NOP;
        dmem_enable        = 1'b0;
        dmem_write_enable  = 1'b0;
        reg_write_mux_ctrl = WBM_LINK;
        br_op              = BR_SEQ;
        halted             = 1'b0;

        // ALU controls stay stable from EXEC through MEM/WB
        if (legal && (state == S_EXEC || state == S_MEM || state == S_WB)) begin
            case (op_q)
                OP_ALU_R: begin
                    case (func_q)
                        F_ADD:   alu_op = ALU_ADD;
                        F_COMP:  alu_op = ALU_COMP;
                        F_AND:   alu_op = ALU_AND;
                        F_XOR:   alu_op = ALU_XOR;
                        F_SHLL:  alu_op = ALU_SHLL;
                        F_SHRL:  alu_op = ALU_SHRL;
                        F_SHLLV: alu_op = ALU_SHLLV;
                        F_SHRLV: alu_op = ALU_SHRLV;
                        F_SHRA:  alu_op = ALU_SHRA;
                        F_SHRAV: alu_op = ALU_SHRAV;
                        default: alu_op = ALU_NOP;
                    endcase
                end
                OP_ADDI: begin
                    alu_op       = ALU_ADD;
                    alu_mux_ctrl = 1'b1;
                end
                OP_COMPI: begin
                    alu_op       = ALU_COMP;
                    alu_mux_ctrl = 1'b1;
                end
                OP_LW, OP_SW: begin
                    alu_op       = ALU_ADD;
                    alu_mux_ctrl = 1'b1;
                    imm_mux_ctrl = 1'b1;
                end
                default: ;
            endcase
        end

        case (state)
            S_EXEC: begin
                if (!legal) begin
                    // Unknown encoding retires as a NOP
                    pc_en = 1'b1;
                end else if (op_q == OP_BR) begin
                    pc_en = 1'b1;
                    case (func_q)
                        F_BR:    br_op = BR_UNC;
                        F_BLTZ:  br_op = BR_BLTZ;
                        F_BZ:    br_op = BR_BZ;
                        F_BNZ:   br_op = BR_BNZ;
                        F_BL:    br_op = BR_BL;
                        F_BCY:   br_op = BR_BCY;
                        F_BNCY:  br_op = BR_BNCY;
                        default: br_op = BR_SEQ;
                    endcase
                    if (func_q == F_BL) begin
                        reg_write          = RW_LINK;
                        reg_write_mux_ctrl = WBM_LINK;
                    end
                end
            end
            S_MEM: begin
                dmem_enable = 1'b1;
                if (op_q == OP_SW) begin
                    dmem_write_enable = 1'b1;
                    pc_en             = 1'b1;
                end
            end
            S_WB: begin
                reg_write          = RW_RS;
                pc_en              = 1'b1;
                reg_write_mux_ctrl = (op_q == OP_LW) ? WBM_MEM : WBM_ALU;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the mini-RISC datapath.
// Owns the state register, opcode/func latches and retired-instruction counter.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown encodings trap to HALT and
// raise illegal_instr instead of retiring as a NOP).
module multicycle_controller
    import mini_risc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    state_t           state;
    logic [5:0]       op_q;
    logic [5:0]       func_q;
    logic [CNT_W-1:0] count_q;
    logic             pc_en;
    logic [3:0]       alu_op;

    ctrl_decode u_decode (
        .state              (state),
        .op_q               (op_q),
        .func_q             (func_q),
        .pc_en              (pc_en),
        .reg_write          (bus.reg_write),
        .imm_mux_ctrl       (bus.imm_mux_ctrl),
        .alu_mux_ctrl       (bus.alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (bus.dmem_enable),
        .dmem_write_enable  (bus.dmem_write_enable),
        .reg_write_mux_ctrl (bus.reg_write_mux_ctrl),
        .br_op              (bus.br_op),
        .halted             (bus.halted)
    );

    assign bus.pc_en       = pc_en;
    assign bus.alu_op      = alu_op;
    assign bus.instr_count = count_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign bus.illegal_instr = illegal_q;
`endif

    // State sequencing, instruction latch and retire counter; the final state
    // of every instruction is exactly the one where decode raises pc_en
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            op_q    <= '0;
            func_q  <= '0;
            count_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (pc_en) count_q <= count_q + 1'b1;
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q   <= bus.opcode;
                    func_q <= bus.func;
                    if (bus.opcode == OP_HALT) begin
                        state <= S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    end else if (!is_legal(bus.opcode, bus.func)) begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
`endif
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (pc_en)                                state <= S_FETCH;
                    else if (op_q == OP_LW || op_q == OP_SW)  state <= S_MEM;
                    else                                      state <= S_WB;
                end
                S_MEM:   state <= pc_en ? S_FETCH : S_WB;
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;
    import mini_risc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(32)) bus ();
    multicycle_controller_if #(.CNT_W(2))  bus_w ();

    multicycle_controller #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter instance used to exercise counter wrap-around
    multicycle_controller #(.CNT_W(2)) dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.func   = fn;
    endtask

    initial begin
        bus.opcode   = OP_ALU_R;
        bus.func     = F_ADD;
        bus_w.opcode = OP_BR;
        bus_w.func   = F_BR;

        // Reset state
        repeat (2) tick();
        chk("rst_pc_en", bus.pc_en, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_br_op", bus.br_op, BR_SEQ);
        chk("rst_halted", bus.halted, 0);
        chk("rst_count", bus.instr_count, 0);
        chk("rst_dmem", bus.dmem_enable, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("rst_illegal", bus.illegal_instr, 0);
`endif
        rst = 1'b0;

        // ADD: cycles FETCH(1) DECODE(2) EXEC(3) WB(4)
        set_instr(OP_ALU_R, F_ADD);
        chk("add_c1_pc_en", bus.pc_en, 0);
        tick();
        chk("add_c2_pc_en", bus.pc_en, 0);
        tick();
        chk("add_c3_pc_en", bus.pc_en, 0);
        chk("add_c3_alu_op", bus.alu_op, ALU_ADD);
        tick();
        chk("add_c4_pc_en", bus.pc_en, 1);
        chk("add_c4_reg_write", bus.reg_write, RW_RS);
        chk("add_c4_mux", bus.reg_write_mux_ctrl, WBM_ALU);
        chk("add_c4_alu_mux", bus.alu_mux_ctrl, 0);
        chk("add_c4_count", bus.instr_count, 0);
        tick();
        chk("add_c5_pc_en", bus.pc_en, 0);
        chk("add_count", bus.instr_count, 1);

        // LW: FETCH DECODE EXEC MEM WB
        set_instr(OP_LW, 6'd0);
        tick(); tick();
        chk("lw_c3_pc_en", bus.pc_en, 0);
        chk("lw_c3_imm_mux", bus.imm_mux_ctrl, 1);
        tick();
        chk("lw_c4_dmem_en", bus.dmem_enable, 1);
        chk("lw_c4_dmem_we", bus.dmem_write_enable, 0);
        chk("lw_c4_pc_en", bus.pc_en, 0);
        tick();
        chk("lw_c5_pc_en", bus.pc_en, 1);
        chk("lw_c5_reg_write", bus.reg_write, RW_RS);
        chk("lw_c5_mux", bus.reg_write_mux_ctrl, WBM_MEM);
        chk("lw_c5_imm_mux", bus.imm_mux_ctrl, 1);
        chk("lw_c5_alu_mux", bus.alu_mux_ctrl, 1);
        tick();
        chk("lw_count", bus.instr_count, 2);

        // SW: FETCH DECODE EXEC MEM
        set_instr(OP_SW, 6'd0);
        tick(); tick();
        chk("sw_c3_reg_write", bus.reg_write, RW_NONE);
        chk("sw_c3_pc_en", bus.pc_en, 0);
        tick();
        chk("sw_c4_dmem_en", bus.dmem_enable, 1);
        chk("sw_c4_dmem_we", bus.dmem_write_enable, 1);
        chk("sw_c4_pc_en", bus.pc_en, 1);
        chk("sw_c4_reg_write", bus.reg_write, RW_NONE);
        tick();
        chk("sw_c5_pc_en", bus.pc_en, 0);
        chk("sw_count", bus.instr_count, 3);

        // BL: FETCH DECODE EXEC, back in FETCH on cycle 4
        set_instr(OP_BR, F_BL);
        tick(); tick();
        chk("bl_c3_br_op", bus.br_op, BR_BL);
        chk("bl_c3_reg_write", bus.reg_write, RW_LINK);
        chk("bl_c3_mux", bus.reg_write_mux_ctrl, WBM_LINK);
        chk("bl_c3_pc_en", bus.pc_en, 1);
        tick();
        chk("bl_c4_pc_en", bus.pc_en, 0);
        chk("bl_c4_br_op", bus.br_op, BR_SEQ);
        chk("bl_count", bus.instr_count, 4);

        // BZ: branch without link
        set_instr(OP_BR, F_BZ);
        tick(); tick();
        chk("bz_c3_br_op", bus.br_op, BR_BZ);
        chk("bz_c3_reg_write", bus.reg_write, RW_NONE);
        chk("bz_c3_pc_en", bus.pc_en, 1);
        tick();
        chk("bz_count", bus.instr_count, 5);

        // COMPI: immediate ALU class
        set_instr(OP_COMPI, 6'd0);
        tick(); tick();
        chk("compi_c3_alu_op", bus.alu_op, ALU_COMP);
        chk("compi_c3_alu_mux", bus.alu_mux_ctrl, 1);
        chk("compi_c3_imm_mux", bus.imm_mux_ctrl, 0);
        tick();
        chk("compi_c4_pc_en", bus.pc_en, 1);
        chk("compi_c4_mux", bus.reg_write_mux_ctrl, WBM_ALU);
        tick();
        chk("compi_count", bus.instr_count, 6);

        // Reset during MEM of LW
        set_instr(OP_LW, 6'd0);
        tick(); tick(); tick();
        chk("rstmem_pre_dmem_en", bus.dmem_enable, 1);
        rst = 1'b1;
        tick();
        chk("rstmem_dmem_en", bus.dmem_enable, 0);
        chk("rstmem_pc_en", bus.pc_en, 0);
        chk("rstmem_reg_write", bus.reg_write, RW_NONE);
        chk("rstmem_count", bus.instr_count, 0);
        rst = 1'b0;
        tick();
        chk("rstmem_decode_pc_en", bus.pc_en, 0);
        tick();
        chk("rstmem_restart_imm", bus.imm_mux_ctrl, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Unknown opcode
        set_instr(6'd7, 6'd0);
        tick(); tick();
`ifdef ILLEGAL_TRAP_EN
        chk("ill_halted", bus.halted, 1);
        chk("ill_flag", bus.illegal_instr, 1);
        chk("ill_pc_en", bus.pc_en, 0);
        tick();
        chk("ill_count", bus.instr_count, 0);
`else
        chk("nop_pc_en", bus.pc_en, 1);
        chk("nop_br_op", bus.br_op, BR_SEQ);
        chk("nop_reg_write", bus.reg_write, RW_NONE);
        chk("nop_dmem", bus.dmem_enable, 0);
        tick();
        chk("nop_count", bus.instr_count, 1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // HALT: halted from cycle 3, absorbing
        set_instr(OP_HALT, 6'd0);
        tick();
        chk("halt_c2_halted", bus.halted, 0);
        tick();
        chk("halt_c3_halted", bus.halted, 1);
        set_instr(OP_ALU_R, F_ADD);
        for (int i = 0; i < 20; i++) begin
            chk("halt_pc_en", bus.pc_en, 0);
            tick();
        end
        chk("halt_still", bus.halted, 1);
        chk("halt_count", bus.instr_count, 0);

        // Counter wrap on the 2-bit instance: four 3-cycle branches
        rst_w = 1'b0;
        repeat (9) tick();
        chk("wrap_pre", bus_w.instr_count, 3);
        repeat (3) tick();
        chk("wrap_zero", bus_w.instr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
